// File: rtl/rom_share_arbiter.sv
// rom_share_arbiter: shares one single-port ROM RAM between HPS download writes and CPU/video reads,
// and holds the game core in reset until a download has settled.
module rom_share_arbiter #(
    parameter int ROM_AW      = 15,
    parameter int ROM_SIZE    = 32768,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              Reset_n,
    input  logic              dn_busy,
    input  logic              dn_wr,
    input  logic [16:0]       dn_addr,
    input  logic [7:0]        dn_data,
    input  logic              cpu_req,
    input  logic [ROM_AW-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_data,
    input  logic              vid_req,
    input  logic [ROM_AW-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_data,
    output logic [ROM_AW-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    input  logic [7:0]        mem_dout,
    output logic              core_hold_n,
    output logic              dn_err
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_DONE} state_t;
    state_t state, state_nx;
    logic pend, gnt_vid, last_vid, pick_vid, in_range;
    logic [ROM_AW-1:0] wr_addr;
    logic [7:0] wr_data;
    logic [CW-1:0] hold_cnt;
    assign in_range    = {15'd0, dn_addr} < 32'(ROM_SIZE);
    assign core_hold_n = !dn_busy && hold_cnt == '0;
    assign pick_vid    = vid_req && (!cpu_req || !last_vid);
    assign mem_we      = state == WRITE;
    assign cpu_ack     = state == RD_DONE && !gnt_vid;
    assign vid_ack     = state == RD_DONE && gnt_vid;
    always_comb begin
        state_nx = IDLE;
        unique case (state)
            IDLE:     state_nx = pend ? WRITE : (core_hold_n && (cpu_req || vid_req)) ? RD_ISSUE : IDLE;
            RD_ISSUE: state_nx = RD_WAIT;
            RD_WAIT:  state_nx = RD_DONE;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            pend     <= 1'b0;
            dn_err   <= 1'b0;
            gnt_vid  <= 1'b0;
            last_vid <= 1'b1;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_data <= '0;
            vid_data <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            hold_cnt <= CW'(HOLD_CYCLES);
        end else begin
            state    <= state_nx;
            hold_cnt <= dn_busy ? CW'(HOLD_CYCLES) : hold_cnt - CW'(hold_cnt != '0);
            if (state == IDLE && pend) begin
                mem_addr <= wr_addr;
                mem_din  <= wr_data;
                pend     <= 1'b0;
            end else if (state_nx == RD_ISSUE) begin
                mem_addr <= pick_vid ? vid_addr : cpu_addr;
                gnt_vid  <= pick_vid;
            end
            if (state == RD_ISSUE)
                last_vid <= gnt_vid;
            if (state == RD_WAIT && gnt_vid)
                vid_data <= mem_dout;
            if (state == RD_WAIT && !gnt_vid)
                cpu_data <= mem_dout;
            // A write arriving while one is still buffered is dropped; the older byte wins
            if (dn_wr && (!in_range || pend))
                dn_err <= 1'b1;
            else if (dn_wr) begin
                pend    <= 1'b1;
                wr_addr <= dn_addr[ROM_AW-1:0];
                wr_data <= dn_data;
            end
        end
    end
endmodule

// File: tb/tb_rom_share_arbiter.sv
// tb_rom_share_arbiter: randomized self-checking bench for rom_share_arbiter with an
// external synchronous RAM and a transaction-level expected-memory model.
module tb_rom_share_arbiter;
    localparam int AW   = 15;
    localparam int HOLD = 16;
    logic clk_sys = 1'b0, Reset_n = 1'b1, dn_busy = 1'b0, dn_wr = 1'b0;
    logic [16:0] dn_addr = '0;
    logic [7:0] dn_data = '0;
    logic cpu_req = 1'b0, vid_req = 1'b0, cpu_ack, vid_ack, mem_we, core_hold_n, dn_err;
    logic [AW-1:0] cpu_addr = '0, vid_addr = '0, mem_addr;
    logic [7:0] cpu_data, vid_data, mem_din, mem_dout;
    logic tb_we = 1'b0;
    logic [AW-1:0] tb_addr = '0;
    logic [7:0] tb_data = '0;
    logic [7:0] ram [0:32767];
    logic [7:0] exp_ram [0:32767];
    logic [AW-1:0] addrs [12];
    int checks = 0, errors = 0;
    bit overlap_seen = 1'b0;
    bit model_last_vid = 1'b1;

    rom_share_arbiter dut (
        .clk_sys(clk_sys), .Reset_n(Reset_n), .dn_busy(dn_busy), .dn_wr(dn_wr),
        .dn_addr(dn_addr), .dn_data(dn_data), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ack(cpu_ack), .cpu_data(cpu_data), .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_data(vid_data), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_dout(mem_dout), .core_hold_n(core_hold_n), .dn_err(dn_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        if (tb_we) ram[tb_addr] <= tb_data;
        mem_dout <= ram[mem_addr];
    end

    always @(negedge clk_sys) if (cpu_ack && vid_ack) overlap_seen <= 1'b1;

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        tick;
        tb_we = 1'b0;
        exp_ram[a] = d;
    endtask

    task automatic apply_reset;
        cpu_req = 1'b0; vid_req = 1'b0; dn_busy = 1'b0; dn_wr = 1'b0;
        Reset_n = 1'b0;
        tick;
        Reset_n = 1'b1;
        repeat (HOLD) tick;
        model_last_vid = 1'b1;
    endtask

    task automatic wait_ack(output bit who, output int lat);
        lat = -1; who = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if (cpu_ack || vid_ack) begin
                who = vid_ack; lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        tick;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_ack, vid_ack, mem_we, dn_err, core_hold_n, cpu_data, vid_data, mem_addr, mem_din} !== '0) begin
            errors++;
            $display("FAIL reset_outputs ack=%b%b we=%b err=%b hold_n=%b cd=%h vd=%h ma=%h md=%h required all zero",
                     cpu_ack, vid_ack, mem_we, dn_err, core_hold_n, cpu_data, vid_data, mem_addr, mem_din);
        end
        tick;
        Reset_n = 1'b1;
        for (int k = 1; k <= HOLD; k++) begin
            tick;
            if (k == HOLD - 1) begin
                checks++;
                if (core_hold_n !== 1'b0) begin errors++; $display("FAIL reset_hold_early core_hold_n=%b required 0", core_hold_n); end
            end
        end
        checks++;
        if (core_hold_n !== 1'b1) begin errors++; $display("FAIL reset_hold_release core_hold_n=%b required 1", core_hold_n); end
        model_last_vid = 1'b1;
    endtask

    task automatic test_contention;
        bit who, exp_who;
        int lat;
        preload(15'h0444, 8'h44);
        preload(15'h0555, 8'h55);
        cpu_addr = 15'h0444; vid_addr = 15'h0555;
        cpu_req = 1'b1; vid_req = 1'b1;
        exp_who = !model_last_vid;
        for (int g = 0; g < 4; g++) begin
            wait_ack(who, lat);
            checks++;
            if (lat != (g == 0 ? 3 : 4) || who !== exp_who) begin
                errors++;
                $display("FAIL contention_grant%0d lat=%0d who=%0d required lat=%0d who=%0d", g, lat, who, g == 0 ? 3 : 4, exp_who);
            end
            checks++;
            if ((who ? vid_data : cpu_data) !== exp_ram[who ? vid_addr : cpu_addr]) begin
                errors++;
                $display("FAIL contention_data%0d got=%h required=%h", g, who ? vid_data : cpu_data, exp_ram[who ? vid_addr : cpu_addr]);
            end
            model_last_vid = who;
            exp_who = !exp_who;
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (2) tick;
    endtask

    task automatic test_single_read;
        bit who;
        int lat;
        preload(15'h0123, 8'hA5);
        cpu_addr = 15'h0123;
        cpu_req = 1'b1;
        wait_ack(who, lat);
        cpu_req = 1'b0;
        checks++;
        if (lat != 3 || who !== 1'b0 || cpu_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_read lat=%0d who=%0d data=%h required lat=3 who=0 data=a5", lat, who, cpu_data);
        end
        model_last_vid = 1'b0;
        tick;
        checks++;
        if (cpu_ack !== 1'b0 || cpu_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_read_pulse ack=%b data=%h required ack=0 data=a5", cpu_ack, cpu_data);
        end
    endtask

    task automatic test_random_reads;
        bit who, exp_first;
        int lat, mode;
        for (int i = 0; i < 12; i++) begin
            addrs[i] = AW'($urandom_range(0, 32767));
            preload(addrs[i], 8'($urandom));
        end
        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 2);
            cpu_addr = addrs[$urandom_range(0, 11)];
            vid_addr = addrs[$urandom_range(0, 11)];
            cpu_req = mode != 1;
            vid_req = mode != 0;
            exp_first = mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : !model_last_vid;
            wait_ack(who, lat);
            if (who) vid_req = 1'b0; else cpu_req = 1'b0;
            checks++;
            if (lat != 3 || who !== exp_first || (who ? vid_data : cpu_data) !== exp_ram[who ? vid_addr : cpu_addr]) begin
                errors++;
                $display("FAIL random_read%0d lat=%0d who=%0d data=%h required lat=3 who=%0d data=%h",
                         it, lat, who, who ? vid_data : cpu_data, exp_first, exp_ram[exp_first ? vid_addr : cpu_addr]);
            end
            model_last_vid = who;
            if (mode == 2) begin
                wait_ack(who, lat);
                if (who) vid_req = 1'b0; else cpu_req = 1'b0;
                checks++;
                if (lat != 4 || who !== !exp_first || (who ? vid_data : cpu_data) !== exp_ram[who ? vid_addr : cpu_addr]) begin
                    errors++;
                    $display("FAIL random_second%0d lat=%0d who=%0d data=%h required lat=4 who=%0d", it, lat, who, who ? vid_data : cpu_data, !exp_first);
                end
                model_last_vid = who;
            end
            repeat ($urandom_range(1, 3)) tick;
        end
    endtask

    task automatic test_download;
        int ack_i = -1, we_i = -1, we_cnt = 0;
        bit early_ack = 1'b0;
        cpu_addr = 15'h0123;
        cpu_req = 1'b1;
        tick;
        dn_busy = 1'b1; dn_wr = 1'b1; dn_addr = 17'h00010; dn_data = 8'h3C;
        tick;
        dn_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_ack) begin
                ack_i = i; cpu_req = 1'b0;
                checks++;
                if (cpu_data !== 8'hA5) begin errors++; $display("FAIL download_read_data got=%h required=a5", cpu_data); end
            end
            if (mem_we) begin
                we_cnt++; we_i = i;
                checks++;
                if (mem_addr !== 15'h0010 || mem_din !== 8'h3C) begin
                    errors++;
                    $display("FAIL download_write_bus addr=%h din=%h required addr=0010 din=3c", mem_addr, mem_din);
                end
            end
            tick;
        end
        cpu_req = 1'b0;
        exp_ram[15'h0010] = 8'h3C;
        model_last_vid = 1'b0;
        checks++;
        if (ack_i != 1 || we_cnt != 1 || we_i != 3) begin
            errors++;
            $display("FAIL download_order ack_at=%0d we_count=%0d we_at=%0d required ack_at=1 we_count=1 we_at=3", ack_i, we_cnt, we_i);
        end
        vid_addr = 15'h0010;
        vid_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (vid_ack) early_ack = 1'b1;
        end
        checks++;
        if (early_ack) begin errors++; $display("FAIL download_block vid_ack=1 required 0 while dn_busy"); end
        dn_busy = 1'b0;
        ack_i = -1;
        for (int i = 1; i <= 25; i++) begin
            tick;
            if (i == HOLD - 1) begin
                checks++;
                if (core_hold_n !== 1'b0) begin errors++; $display("FAIL download_hold_early core_hold_n=%b required 0", core_hold_n); end
            end
            if (i == HOLD) begin
                checks++;
                if (core_hold_n !== 1'b1) begin errors++; $display("FAIL download_hold_release core_hold_n=%b required 1", core_hold_n); end
            end
            if (vid_ack) begin ack_i = i; break; end
        end
        vid_req = 1'b0;
        model_last_vid = 1'b1;
        checks++;
        if (ack_i != HOLD + 3 || vid_data !== 8'h3C) begin
            errors++;
            $display("FAIL download_vid_read ack_at=%0d data=%h required ack_at=%0d data=3c", ack_i, vid_data, HOLD + 3);
        end
        tick;
    endtask

    task automatic test_hold_reload;
        bit glitch = 1'b0;
        dn_busy = 1'b1;
        tick;
        dn_busy = 1'b0;
        repeat (5) begin tick; if (core_hold_n) glitch = 1'b1; end
        dn_busy = 1'b1;
        tick;
        if (core_hold_n) glitch = 1'b1;
        dn_busy = 1'b0;
        for (int i = 1; i < HOLD; i++) begin tick; if (core_hold_n) glitch = 1'b1; end
        checks++;
        if (glitch) begin errors++; $display("FAIL hold_reload_glitch core_hold_n=1 required 0 during hold"); end
        tick;
        checks++;
        if (core_hold_n !== 1'b1) begin errors++; $display("FAIL hold_reload_release core_hold_n=%b required 1", core_hold_n); end
    endtask

    task automatic test_errors;
        int we_cnt = 0;
        bit who;
        int lat;
        apply_reset;
        dn_wr = 1'b1; dn_addr = 17'h08000; dn_data = 8'h55;
        tick;
        dn_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin if (mem_we) we_cnt++; tick; end
        checks++;
        if (we_cnt != 0 || dn_err !== 1'b1) begin
            errors++;
            $display("FAIL err_range we_count=%0d dn_err=%b required we_count=0 dn_err=1", we_cnt, dn_err);
        end
        apply_reset;
        checks++;
        if (dn_err !== 1'b0) begin errors++; $display("FAIL err_reset_clear dn_err=%b required 0", dn_err); end
        dn_wr = 1'b1; dn_addr = 17'h00020; dn_data = 8'h11;
        tick;
        dn_addr = 17'h00021; dn_data = 8'h22;
        tick;
        dn_wr = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_we) begin
                we_cnt++;
                checks++;
                if (mem_addr !== 15'h0020 || mem_din !== 8'h11) begin
                    errors++;
                    $display("FAIL err_overrun_bus addr=%h din=%h required addr=0020 din=11", mem_addr, mem_din);
                end
            end
            tick;
        end
        exp_ram[15'h0020] = 8'h11;
        checks++;
        if (we_cnt != 1 || dn_err !== 1'b1) begin
            errors++;
            $display("FAIL err_overrun we_count=%0d dn_err=%b required we_count=1 dn_err=1", we_cnt, dn_err);
        end
        cpu_addr = 15'h0020;
        cpu_req = 1'b1;
        wait_ack(who, lat);
        cpu_req = 1'b0;
        model_last_vid = 1'b0;
        checks++;
        if (lat != 3 || cpu_data !== 8'h11) begin
            errors++;
            $display("FAIL err_readback lat=%0d data=%h required lat=3 data=11", lat, cpu_data);
        end
        tick;
    endtask

    task automatic test_mid_read_reset;
        bit late = 1'b0;
        cpu_addr = 15'h0123;
        cpu_req = 1'b1;
        tick;
        tick;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({cpu_ack, vid_ack, mem_we, dn_err, core_hold_n, cpu_data, vid_data, mem_addr, mem_din} !== '0) begin
            errors++;
            $display("FAIL midread_reset ack=%b%b we=%b err=%b hold_n=%b cd=%h vd=%h ma=%h md=%h required all zero",
                     cpu_ack, vid_ack, mem_we, dn_err, core_hold_n, cpu_data, vid_data, mem_addr, mem_din);
        end
        cpu_req = 1'b0;
        tick;
        Reset_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (cpu_ack || vid_ack || mem_we) late = 1'b1;
            if (i == HOLD - 1) begin
                checks++;
                if (core_hold_n !== 1'b0) begin errors++; $display("FAIL midread_hold_early core_hold_n=%b required 0", core_hold_n); end
            end
            if (i == HOLD) begin
                checks++;
                if (core_hold_n !== 1'b1) begin errors++; $display("FAIL midread_hold_release core_hold_n=%b required 1", core_hold_n); end
            end
        end
        checks++;
        if (late) begin errors++; $display("FAIL midread_no_ack ack_or_we=1 required 0 after reset"); end
    endtask

    initial begin
        test_reset;
        test_contention;
        test_single_read;
        test_random_reads;
        test_download;
        test_hold_reload;
        test_errors;
        test_mid_read_reset;
        checks++;
        if (overlap_seen) begin errors++; $display("FAIL ack_overlap cpu_ack&vid_ack=1 required 0"); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
